// File: rtl/vga_feed_pkg.sv
// Shared types and widths for the VGA pixel feeder.
package vga_feed_pkg;

  localparam int unsigned COLOR_W   = 10;
  localparam int unsigned PIX_CNT_W = 19;

  typedef enum logic [1:0] {SEEK, ARMED, STREAM} feed_state_e;

  typedef struct packed {
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
  } rgb_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with a registered read port and a combinational peek of the head word's
// top (tag) bit.
module pixel_fifo #(
  parameter int unsigned WIDTH = 31,
  parameter int unsigned DEPTH = 16
) (
  input  logic             Clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             head_tag,
  output logic [WIDTH-1:0] rd_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_tag = mem[rd_ptr_q][WIDTH-1];

  always_ff @(posedge Clock) begin
    if (do_push) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rd_data  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        rd_data  <= mem[rd_ptr_q];
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/vga_pixel_feeder.sv
// Buffers producer pixels, aligns frames to the controller's vsync and presents RGB two cycles
// after each active strobe. Optional counters enabled by VGA_FEEDER_STATS_EN.
module vga_pixel_feeder
  import vga_feed_pkg::*;
#(
  parameter int unsigned DEPTH            = 16,
  parameter int unsigned PIXELS_PER_FRAME = 307200
) (
  input  logic               Clock,
  input  logic               reset,
  input  logic               s_valid,
  input  logic [29:0]        s_data,
  input  logic               s_sof,
  output logic               s_ready,
  input  logic               vga_active,
  input  logic               vga_v_sync,
  output logic [COLOR_W-1:0] oRed,
  output logic [COLOR_W-1:0] oGreen,
  output logic [COLOR_W-1:0] oBlue,
  output logic               oUnderflow,
  output logic               oSync_err,
  input  logic               clr_err
`ifdef VGA_FEEDER_STATS_EN
  ,
  output logic [15:0]        oFrame_count,
  output logic [15:0]        oDrop_count
`endif
);

  feed_state_e          state_q, state_d;
  logic [PIX_CNT_W-1:0] cnt_q, cnt_d;
  logic                 vsync_q, v_fall;
  logic                 fifo_full, fifo_empty, head_sof;
  logic [30:0]          fifo_rd;
  logic                 pop, set_uf, set_se, clean_eof;
  logic                 s1_valid_q, s1_cnt_nz_q;
  rgb_t                 rgb_q;

  assign s_ready = !fifo_full;
  assign v_fall  = vsync_q && !vga_v_sync;

  pixel_fifo #(
    .WIDTH (31),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clock    (Clock),
    .reset    (reset),
    .push     (s_valid && s_ready),
    .wr_data  ({s_sof, s_data}),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_tag (head_sof),
    .rd_data  (fifo_rd)
  );

  // Frame boundary is clean when exactly one frame was consumed and the next SOF (or nothing)
  // waits at the head.
  assign clean_eof = (state_q == STREAM) && v_fall &&
                     (cnt_q == PIX_CNT_W'(PIXELS_PER_FRAME)) && (fifo_empty || head_sof);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    set_uf  = 1'b0;
    set_se  = 1'b0;
    unique case (state_q)
      SEEK: begin
        if (!fifo_empty) begin
          if (head_sof) state_d = ARMED;
          else          pop     = 1'b1;
        end
      end
      ARMED: begin
        cnt_d = '0;
        if (v_fall) state_d = STREAM;
      end
      STREAM: begin
        if (vga_active) begin
          if (fifo_empty) begin
            set_uf = 1'b1;
          end else begin
            pop   = 1'b1;
            cnt_d = cnt_q + PIX_CNT_W'(1);
            if (head_sof && (cnt_q != '0)) set_se = 1'b1;
          end
        end
        if (v_fall) begin
          if (clean_eof) cnt_d  = '0;
          else           set_se = 1'b1;
        end
        if (set_uf || set_se) state_d = SEEK;
      end
      default: state_d = SEEK;
    endcase
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state_q     <= SEEK;
      cnt_q       <= '0;
      vsync_q     <= 1'b1;
      s1_valid_q  <= 1'b0;
      s1_cnt_nz_q <= 1'b0;
      rgb_q       <= '0;
      oUnderflow  <= 1'b0;
      oSync_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vsync_q     <= vga_v_sync;
      s1_valid_q  <= pop && (state_q == STREAM);
      s1_cnt_nz_q <= (cnt_q != '0);
      // A stray SOF mid-frame is blanked rather than shown.
      rgb_q       <= (s1_valid_q && !(fifo_rd[30] && s1_cnt_nz_q)) ? rgb_t'(fifo_rd[29:0]) : '0;
      if (set_uf)       oUnderflow <= 1'b1;
      else if (clr_err) oUnderflow <= 1'b0;
      if (set_se)       oSync_err  <= 1'b1;
      else if (clr_err) oSync_err  <= 1'b0;
    end
  end

  assign oRed   = rgb_q.red;
  assign oGreen = rgb_q.green;
  assign oBlue  = rgb_q.blue;

`ifdef VGA_FEEDER_STATS_EN
  logic drop;
  assign drop = pop && (state_q == SEEK);

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      oFrame_count <= '0;
      oDrop_count  <= '0;
    end else begin
      if (clean_eof) oFrame_count <= oFrame_count + 16'd1;
      if (drop && (oDrop_count != 16'hFFFF)) oDrop_count <= oDrop_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/vga_pixel_feeder.md
# vga_pixel_feeder

Upstream pixel source for the VGA controller. It buffers an RGB pixel stream from the frame producer in a small FIFO and aligns frames to the controller's vertical sync. It pops one pixel per active-window strobe and presents 10-bit RGB exactly two cycles after the strobe. That matches the controller's early `oVGA_ACTIVE` window, which leads its RGB sampling by two cycles.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in pixels; power of two, ≥ 4.
- `PIXELS_PER_FRAME`, 307200: expected active pixels per frame (640×480).

Ports:
- `Clock`, in, 1: sole clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `s_valid`, in, 1: producer pixel valid.
- `s_data`, in, 30: `{R[29:20], G[19:10], B[9:0]}`.
- `s_sof`, in, 1: marks the first pixel of a frame; qualified by `s_valid`.
- `s_ready`, out, 1: FIFO can accept; equals `!full`.
- `vga_active`, in, 1: `oVGA_ACTIVE` from the controller.
- `vga_v_sync`, in, 1: `oVGA_V_SYNC` from the controller; active-low pulse.
- `oRed`, `oGreen`, `oBlue`, out, 10 each: pixel to the controller.
- `oUnderflow`, out, 1: sticky; pop requested while FIFO empty.
- `oSync_err`, out, 1: sticky; frame misalignment detected.
- `clr_err`, in, 1: synchronous clear of both sticky flags.

## Operation
- Push: occurs when `s_valid && s_ready`. It writes `{s_sof, s_data}`, 31 bits.
- State machine with three states: SEEK, ARMED, STREAM.
- SEEK:
  - Pops and discards the head word every cycle while the FIFO is non-empty and head `sof=0`.
  - Head `sof=1` → ARMED. That word is not popped.
- ARMED:
  - No pops.
  - Falling edge of `vga_v_sync` (registered previous = 1, current = 0) → STREAM.
  - Pixel counter clears to 0.
- STREAM, on each cycle with `vga_active=1`:
  - FIFO non-empty: pop the head and increment the pixel counter (19 bits).
  - FIFO empty: no pop; output pixel forced to 0; set `oUnderflow`; go to SEEK.
- STREAM, on a `vga_v_sync` falling edge:
  - Counter == `PIXELS_PER_FRAME` and head `sof=1` (or FIFO empty): clear the counter and stay in STREAM.
  - Otherwise: set `oSync_err` and go to SEEK.
- A popped word with `sof=1` while the counter ≠ 0: set `oSync_err`, go to SEEK, output that pixel as 0.
- Outside STREAM, or when `vga_active=0`: the pipeline carries a 0 pixel.
- Simultaneous push and pop on an empty FIFO: the pop sees empty, so underflow (no bypass path).
- Push and pop in the same cycle on a non-empty FIFO: occupancy unchanged.
- `clr_err` together with a new error event in the same cycle: the error wins and the flag stays 1.
- Reset values:
  - State SEEK; FIFO empty; counter 0.
  - All RGB outputs 0; `oUnderflow` and `oSync_err` 0.
  - `s_ready` 1 once reset deasserts.
- Reset mid-frame: the FIFO is flushed and the block re-seeks SOF. Producer words in flight are lost.

## Timing
- `vga_active` sampled 1 at cycle n → popped pixel on `oRed/oGreen/oBlue` at cycle n+2.
  - Stage 1: registered FIFO read.
  - Stage 2: output register.
- `s_ready` is combinational from the occupancy register; no dependence on `s_valid`.
- A pushed word is poppable from the cycle after the push.
- A state transition takes effect the cycle after its trigger.
- The pop decision at cycle n uses the state at cycle n.

## Configuration
- Macro: `VGA_FEEDER_STATS_EN`.
- Defined:
  - Adds outputs `oFrame_count[15:0]`, incremented on each clean end-of-frame in STREAM, wrapping at 0xFFFF.
  - Adds `oDrop_count[15:0]`, incremented per word discarded in SEEK, saturating at 0xFFFF.
  - Both reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

## Structure
- Package `vga_feed_pkg` holds:
  - `feed_state_e` (SEEK, ARMED, STREAM).
  - `rgb_t` struct (three 10-bit fields).
  - `COLOR_W = 10`.
  - `PIX_CNT_W = 19`.
- One sub-module: `pixel_fifo`, a synchronous FIFO.
  - Parameters: width, depth.
  - Ports: push, pop, full, empty, registered `rd_data`.
  - Uses the same asynchronous reset.

## Test plan
- Reset, push an SOF frame of 8 pixels (`PIXELS_PER_FRAME=8`), pulse vsync, then `vga_active` for 8 cycles → pixels appear in order exactly 2 cycles after each active cycle; flags stay 0.
- Push 3 words with `sof=0`, then an SOF word → the 3 words are dropped, the block reaches ARMED, and with stats enabled `oDrop_count=3`.
- Fill the FIFO with `DEPTH` words → `s_ready=0`; a further `s_valid` is ignored; one pop → `s_ready=1` next cycle.
- STREAM with the FIFO emptied mid-line, `vga_active` high → that pixel output is 0 at n+2, `oUnderflow=1`, state SEEK.
- Vsync falling edge after only 5 of 8 pixels → `oSync_err=1`; the next frame with correct SOF streams cleanly; `clr_err` clears the flag.
- Assert `reset` mid-STREAM → RGB outputs 0 immediately, FIFO empty, state SEEK.
